// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared lane constants and select decode for the demux lane deserializer
package demux_pkg;
  localparam int NUM_LANES     = 4;
  localparam int LANE_IDX_W    = 2;
  localparam int DEFAULT_WIDTH = 8;

  typedef logic [LANE_IDX_W-1:0] lane_idx_t;

  // Same encoding as the upstream demux case statement: S0 is the index MSB.
  localparam lane_idx_t LANE0 = 2'b00;
  localparam lane_idx_t LANE1 = 2'b01;
  localparam lane_idx_t LANE2 = 2'b10;
  localparam lane_idx_t LANE3 = 2'b11;

  function automatic lane_idx_t lane_index(input logic s0, input logic s1);
    return {s0, s1};
  endfunction
endpackage

// File: rtl/demux_lane_deserializer_if.sv
// rtl/demux_lane_deserializer_if.sv - per-lane word output handshake bundle
interface demux_lane_deserializer_if #(
  parameter int WIDTH = demux_pkg::DEFAULT_WIDTH
);
  logic [demux_pkg::NUM_LANES*WIDTH-1:0] lane_data;
  logic [demux_pkg::NUM_LANES-1:0]       lane_valid;
  logic [demux_pkg::NUM_LANES-1:0]       lane_ready;

  modport master (
    output lane_data,
    output lane_valid,
    input  lane_ready
  );

  modport slave (
    input  lane_data,
    input  lane_valid,
    output lane_ready
  );
endinterface

// File: rtl/demux_rx_lane.sv
// rtl/demux_rx_lane.sv - one lane: shift register, bit counter, held output word and overflow flag
module demux_rx_lane #(
  parameter int WIDTH     = demux_pkg::DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample_en,
  input  logic             sample_bit,
  input  logic             sync_clr,
  input  logic             ready,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             ovf
);
  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_next;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             complete;

  always_comb begin
    sreg_next = sreg;
    if (MSB_FIRST) sreg_next = {sreg[WIDTH-2:0], sample_bit};
    else           sreg_next = {sample_bit, sreg[WIDTH-1:1]};
  end

  // sync_clr outranks a bit arriving on the same edge: that bit is dropped.
  assign accept   = sample_en & ~sync_clr;
  assign complete = accept & (cnt == LAST_BIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (sync_clr) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (accept) begin
      sreg <= sreg_next;
      cnt  <= complete ? '0 : cnt + 1'b1;
    end
  end

  // A finished word may replace the held one only if the held one leaves on this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (complete && (!valid || ready)) begin
      data  <= sreg_next;
      valid <= 1'b1;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         ovf <= 1'b0;
    else if (complete && valid && !ready) ovf <= 1'b1;
    else if (ovf_clr)                   ovf <= 1'b0;
  end
endmodule

// File: rtl/demux_lane_deserializer.sv
// rtl/demux_lane_deserializer.sv - decodes demux select, steers each O-line to its lane, packs lane outputs
module demux_lane_deserializer
  import demux_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  bit_valid,
  input  logic                  s0,
  input  logic                  s1,
  input  logic                  o0,
  input  logic                  o1,
  input  logic                  o2,
  input  logic                  o3,
  input  logic                  sync_clr,
  input  logic                  ovf_clr,
  output logic [NUM_LANES-1:0]  ovf,
  demux_lane_deserializer_if.master lanes
);
  localparam lane_idx_t LANE_CODES [NUM_LANES] = '{LANE0, LANE1, LANE2, LANE3};

  lane_idx_t             sel_idx;
  logic [NUM_LANES-1:0]  lane_bits;

  assign sel_idx   = lane_index(s0, s1);
  assign lane_bits = {o3, o2, o1, o0};

  for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
    demux_rx_lane #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
    ) u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .sample_en  (bit_valid && (sel_idx == LANE_CODES[n])),
      .sample_bit (lane_bits[n]),
      .sync_clr   (sync_clr),
      .ready      (lanes.lane_ready[n]),
      .ovf_clr    (ovf_clr),
      .data       (lanes.lane_data[n*WIDTH +: WIDTH]),
      .valid      (lanes.lane_valid[n]),
      .ovf        (ovf[n])
    );
  end
endmodule

// File: tb/tb_demux_lane_deserializer.sv
// tb/tb_demux_lane_deserializer.sv - directed self-checking bench for demux_lane_deserializer
module tb_demux_lane_deserializer;
  logic clk = 1'b0;
  logic rst_n;
  logic bit_valid, s0, s1, o0, o1, o2, o3, sync_clr, ovf_clr;
  logic [3:0] ovf_m, ovf_l;
  int errors = 0;
  int checks = 0;

  demux_lane_deserializer_if #(.WIDTH(8)) bus_m ();
  demux_lane_deserializer_if #(.WIDTH(8)) bus_l ();

  demux_lane_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .s0(s0), .s1(s1),
    .o0(o0), .o1(o1), .o2(o2), .o3(o3), .sync_clr(sync_clr),
    .ovf_clr(ovf_clr), .ovf(ovf_m), .lanes(bus_m)
  );

  demux_lane_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .s0(s0), .s1(s1),
    .o0(o0), .o1(o1), .o2(o2), .o3(o3), .sync_clr(sync_clr),
    .ovf_clr(ovf_clr), .ovf(ovf_l), .lanes(bus_l)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Non-selected lines carry the inverse bit so any leakage corrupts the word.
  task automatic drive_bit(input logic [1:0] lane, input logic b);
    @(negedge clk);
    bit_valid = 1'b1;
    {s0, s1} = lane;
    {o3, o2, o1, o0} = {4{~b}};
    case (lane)
      2'd0: o0 = b;
      2'd1: o1 = b;
      2'd2: o2 = b;
      default: o3 = b;
    endcase
  endtask

  task automatic drive_word(input logic [1:0] lane, input logic [7:0] w);
    for (int i = 7; i >= 0; i--) drive_bit(lane, w[i]);
  endtask

  task automatic idle();
    @(negedge clk);
    bit_valid = 1'b0;
    sync_clr  = 1'b0;
    ovf_clr   = 1'b0;
    {o3, o2, o1, o0} = 4'b0000;
  endtask

  initial begin
    logic [7:0] wa;
    logic [7:0] wb;
    rst_n = 1'b0; bit_valid = 1'b0; s0 = 1'b0; s1 = 1'b0;
    {o3, o2, o1, o0} = 4'b0000; sync_clr = 1'b0; ovf_clr = 1'b0;
    bus_m.lane_ready = 4'hF;
    bus_l.lane_ready = 4'hF;
    repeat (2) @(negedge clk);
    chk("rst_data", bus_m.lane_data, 32'h0);
    chk("rst_valid", {28'h0, bus_m.lane_valid}, 32'h0);
    chk("rst_ovf", {28'h0, ovf_m}, 32'h0);
    rst_n = 1'b1;

    // Lane 2, MSB first, A5.
    drive_word(2'd2, 8'hA5);
    idle();
    chk("t1_valid", {28'h0, bus_m.lane_valid}, 32'h4);
    chk("t1_data", bus_m.lane_data, 32'h00A5_0000);
    idle();
    chk("t1_valid_drop", {28'h0, bus_m.lane_valid}, 32'h0);
    chk("t1_data_hold", bus_m.lane_data, 32'h00A5_0000);

    // Interleave lane0 3C with lane3 F0.
    wa = 8'h3C; wb = 8'hF0;
    for (int i = 7; i >= 0; i--) begin
      drive_bit(2'd0, wa[i]);
      drive_bit(2'd3, wb[i]);
    end
    chk("t2_l0_valid", {28'h0, bus_m.lane_valid}, 32'h1);
    chk("t2_l0_data", {24'h0, bus_m.lane_data[7:0]}, 32'h3C);
    idle();
    chk("t2_l3_valid", {28'h0, bus_m.lane_valid}, 32'h8);
    chk("t2_data", bus_m.lane_data, 32'hF0A5_003C);
    chk("t2_ovf", {28'h0, ovf_m}, 32'h0);

    // Lane 1 overflow while unready.
    bus_m.lane_ready = 4'b1101;
    drive_word(2'd1, 8'h11);
    idle();
    chk("t3_valid1", {31'h0, bus_m.lane_valid[1]}, 32'h1);
    chk("t3_data1", {24'h0, bus_m.lane_data[15:8]}, 32'h11);
    drive_word(2'd1, 8'h22);
    idle();
    chk("t3_data_kept", {24'h0, bus_m.lane_data[15:8]}, 32'h11);
    chk("t3_ovf_set", {28'h0, ovf_m}, 32'h2);
    chk("t3_valid_held", {31'h0, bus_m.lane_valid[1]}, 32'h1);
    bus_m.lane_ready = 4'hF;
    idle();
    chk("t3_valid_xfer", {31'h0, bus_m.lane_valid[1]}, 32'h0);
    chk("t3_data_after", {24'h0, bus_m.lane_data[15:8]}, 32'h11);
    chk("t3_ovf_sticky", {28'h0, ovf_m}, 32'h2);
    @(negedge clk);
    ovf_clr = 1'b1;
    idle();
    chk("t3_ovf_clr", {28'h0, ovf_m}, 32'h0);

    // Lane 0 continuous words 01, 02.
    wa = 8'h01; wb = 8'h02;
    for (int i = 0; i < 16; i++) begin
      drive_bit(2'd0, (i < 8) ? wa[7-i] : wb[15-i]);
      chk("t4_valid", {31'h0, bus_m.lane_valid[0]}, {31'h0, (i == 8)});
      if (i == 8) chk("t4_word1", {24'h0, bus_m.lane_data[7:0]}, 32'h01);
    end
    idle();
    chk("t4_valid2", {31'h0, bus_m.lane_valid[0]}, 32'h1);
    chk("t4_word2", {24'h0, bus_m.lane_data[7:0]}, 32'h02);
    idle();
    chk("t4_valid2_drop", {31'h0, bus_m.lane_valid[0]}, 32'h0);

    // Partial word on lane 2, sync_clr with a simultaneous bit, then C3.
    for (int i = 0; i < 5; i++) drive_bit(2'd2, 1'b1);
    drive_bit(2'd2, 1'b1);
    sync_clr = 1'b1;
    @(negedge clk);
    sync_clr = 1'b0;
    bit_valid = 1'b0;
    chk("t5_no_valid", {28'h0, bus_m.lane_valid}, 32'h0);
    drive_word(2'd2, 8'hC3);
    idle();
    chk("t5_clr_valid", {28'h0, bus_m.lane_valid}, 32'h4);
    chk("t5_clr_data", {24'h0, bus_m.lane_data[23:16]}, 32'hC3);
    idle();

    // Same with reset pulsed mid-word.
    for (int i = 0; i < 5; i++) drive_bit(2'd2, 1'b1);
    idle();
    rst_n = 1'b0;
    #1;
    chk("t5_rst_data", bus_m.lane_data, 32'h0);
    chk("t5_rst_valid", {28'h0, bus_m.lane_valid}, 32'h0);
    chk("t5_rst_ovf", {28'h0, ovf_m}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive_word(2'd2, 8'hC3);
    idle();
    chk("t5_rst_word", bus_m.lane_data, 32'h00C3_0000);
    chk("t5_rst_wvalid", {28'h0, bus_m.lane_valid}, 32'h4);

    // LSB-first instance: 1,1,0,0,0,0,0,0 on lane 3.
    drive_word(2'd3, 8'hC0);
    idle();
    chk("t6_lsb_data", {24'h0, bus_l.lane_data[31:24]}, 32'h03);
    chk("t6_lsb_valid", {31'h0, bus_l.lane_valid[3]}, 32'h1);
    chk("t6_msb_data", {24'h0, bus_m.lane_data[31:24]}, 32'hC0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/demux_lane_deserializer.md
Name: demux_lane_deserializer

Overview:
- Sits directly downstream of the 1-to-4 demultiplexer and consumes its four outputs O0..O3 plus the select pair that steered them.
- Each lane shifts in the bits routed to it and assembles WIDTH-bit words.
- Completed words are presented per lane with a valid/ready handshake.
- One double-buffered lane per channel, so a lane keeps shifting while its previous word waits for the consumer.

Parameters:
- WIDTH, 8: bits per assembled word; legal range 2..32.
- MSB_FIRST, 1: 1 = first received bit lands in word bit WIDTH-1; 0 = first bit lands in bit 0.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- bit_valid  in  1  demux outputs and select carry a valid bit this cycle.
- s0  in  1  demux select S0 (MSB of lane index).
- s1  in  1  demux select S1 (LSB of lane index).
- o0  in  1  demux output O0 (lane 0).
- o1  in  1  demux output O1 (lane 1).
- o2  in  1  demux output O2 (lane 2).
- o3  in  1  demux output O3 (lane 3).
- sync_clr  in  1  synchronous clear of all shift registers and bit counters; output registers are untouched.
- lane_data  out  4*WIDTH  lane n word at bits [n*WIDTH +: WIDTH].
- lane_valid  out  4  per-lane word-available flag.
- lane_ready  in  4  per-lane consumer accept.
- ovf  out  4  sticky per-lane overflow flag.
- ovf_clr  in  1  clears all ovf bits, synchronously.

Behaviour:
- Reset (rst_n low, async): lane_data=0, lane_valid=0, ovf=0, all shift registers=0, all bit counters=0.
- Lane index = {s0,s1}, matching the demux case encoding (00→O0, 01→O1, 10→O2, 11→O3).
- Only the selected lane samples, and it samples only its own o-line. Non-selected lines are ignored. A 0 bit is distinguished from "not selected" by select alone.
- Accepted bit (bit_valid=1): the selected lane's shift register and counter update on that edge.
  - MSB_FIRST=1: sreg <= {sreg[WIDTH-2:0], bit}.
  - MSB_FIRST=0: sreg <= {bit, sreg[WIDTH-1:1]}.
  - Counter increments 0..WIDTH-1, then wraps to 0.
- Word completion: an accepted bit while counter==WIDTH-1.
  - The assembled word, including this bit, is offered to the output register.
  - The counter returns to 0.
- Output register load rules at the completion edge:
  - lane_valid=0: load the word, set lane_valid=1. Latency is 1 clock from the last bit's edge to valid visible.
  - lane_valid=1 and lane_ready=1 in the same cycle: load the new word and keep lane_valid=1 (back-to-back, no bubble).
  - lane_valid=1 and lane_ready=0: discard the new word, keep the old word unchanged, set ovf[n]=1.
- Handshake:
  - Transfer happens when lane_valid & lane_ready are high at a clock edge. Without a new completion, lane_valid clears on that edge.
  - lane_data is stable while lane_valid=1 and lane_ready=0.
  - lane_data holds its last value after the transfer; it is not zeroed.
- sync_clr:
  - Zeroes every sreg and counter. Any partial word is dropped.
  - Has priority over a simultaneous accepted bit; that bit is discarded.
  - Does not affect lane_valid, lane_data or ovf.
- ovf_clr: clears ovf. If an overflow event occurs on the same edge, ovf for that lane ends up 1 (set wins).
- Lanes are fully independent. Interleaved selects accumulate partial words per lane without interference.
- Reset asserted mid-word: all partial state is lost. After release, the first accepted bit is bit 0 of a new word.

Decomposition:
- Shared package demux_pkg holds:
  - NUM_LANES=4 and LANE_IDX_W=2.
  - Lane index constants LANE0..LANE3 (2'b00..2'b11), matching demux select encoding.
  - Default WIDTH.
- Sub-module demux_rx_lane, one per lane, instantiated 4 times by generate. It contains:
  - sreg, counter, output register, valid, ovf.
  - Inputs: sample_en (bit_valid & index match), bit, sync_clr, ready, ovf_clr.
- The top level holds only index decode, per-lane bit muxing and output packing.

Test Plan:
- Reset then 8 bits 1,0,1,0,0,1,0,1 on lane 2 (s0=1,s1=0), ready=1, MSB_FIRST=1 → lane_data[23:16]=8'hA5, lane_valid=4'b0100 for one cycle starting 1 clock after the 8th bit; other lanes stay 0.
- Interleave lane0 bits of 8'h3C with lane3 bits of 8'hF0, alternating each cycle → lane0 word 8'h3C, lane3 word 8'hF0; no cross-contamination; ovf=0.
- Lane1 completes 8'h11 with ready=0, then 8'h22 completes while still unready → lane_data[15:8] stays 8'h11 and ovf[1]=1. Then raise ready → one transfer of 8'h11; ovf stays 1 until ovf_clr.
- Lane0 with ready=1 and continuous bits → words 8'h01, 8'h02 complete on consecutive word boundaries; each accepted with no lost word; valid high exactly 1 cycle per word.
- 5 bits into lane2, then sync_clr, then 8 bits of 8'hC3 → output 8'hC3, not mixed with the old partial bits. Repeat with rst_n pulsed low mid-word → same result; all outputs 0 during reset.
- MSB_FIRST=0, bits 1,1,0,0,0,0,0,0 on lane3 → lane_data[31:24]=8'h03.
